window_scan_ctrl: RTL
=====================

Name: window_scan_ctrl

Overview:
- Sequencer for a padded-frame 3x3 window memory and the kernel pipeline behind it.
- On `start`, issues one window read per cycle in raster order, together with the window base address and row/column position.
- Tracks the read and kernel latency and asserts the write strobe plus the write address for the result memory.
- Signals busy and done to the top-level tile scheduler.

Parameters:
- IMG_W, 256, output columns per row (unpadded width).
- IMG_H, 32, output rows per tile.
- PAD_W, 258, padded row pitch in memory words (IMG_W+2).
- RD_LAT, 1, cycles from rd to window pixels valid.
- PIPE_LAT, 3, kernel pipeline cycles from window valid to result valid.
- AW, 15, read base address width.
- WAW, 13, write address width (log2(IMG_W*IMG_H)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to scan one tile; ignored unless IDLE.
- stall  in  1  hold read issue this cycle (upstream not ready).
- rd  out  1  window read strobe to memory.
- rd_base  out  AW  window top-left address = row*PAD_W + col.
- col  out  9  current output column, 0..IMG_W-1.
- row  out  6  current output row, 0..IMG_H-1.
- wr  out  1  result write strobe.
- wr_addr  out  WAW  result address, increments per write.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; rd=0, wr=0, busy=0, done=0; rd_base, col, row and wr_addr all 0; latency delay line cleared.
- Reset mid-scan aborts immediately. No further rd or wr is issued.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE:
  - start=1 -> SCAN next cycle.
  - col, row and rd_base cleared; wr_addr cleared.
- SCAN:
  - rd = !stall, combinational from state and stall. rd_base, col and row are registered.
  - On each rd cycle, col increments.
  - At col==IMG_W-1, col wraps to 0 and row increments.
  - rd_base is computed from row*PAD_W+col with a running-sum register: +1 per column, +3 at row wrap. No multiplier.
  - On the rd cycle with col==IMG_W-1 and row==IMG_H-1 -> DRAIN.
  - Exactly IMG_W*IMG_H rd pulses per tile.
- Stall: freezes col, row and rd_base only. The delay line keeps shifting and inserts a bubble, so the kernel pipeline is never stalled.
- Delay line: shift register of depth RD_LAT+PIPE_LAT (default 4), fed with rd.
  - wr = delay-line output, so wr follows each rd by exactly RD_LAT+PIPE_LAT cycles, bubbles preserved.
  - wr_addr increments after each wr cycle and wraps to 0 at 2^WAW.
- DRAIN:
  - rd=0; waits until the delay line is empty and the last wr has been issued.
  - Then -> FIN.
- FIN: done=1 for one cycle, busy drops in the same cycle, -> IDLE.
- busy is 1 in SCAN and DRAIN, 0 in IDLE and FIN.
- start during SCAN, DRAIN or FIN is ignored and not queued. start in the same cycle as FIN is also ignored.
- stall in DRAIN or IDLE has no effect.
- Latency from start to first rd: 1 cycle. Start to done with no stalls: 1 + IMG_W*IMG_H + RD_LAT + PIPE_LAT cycles.

Decomposition:
- Shared package scan_pkg:
  - constants IMG_W, IMG_H, PAD_W, RD_LAT, PIPE_LAT;
  - FSM state enum scan_state_t;
  - derived widths AW and WAW.
- One natural sub-module: valid_delay_line (parameter DEPTH, in/out 1-bit, clear on rst_n). It is reused wherever kernel latency is tracked.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset then start, no stall -> first rd one cycle after start with rd_base=0, col=0, row=0. rd_base=255 at col 255. Next rd has rd_base=258, row=1, col=0. 8192 rd pulses total. First wr 4 cycles after the first rd, with wr_addr=0.
- Full tile, no stall -> last rd_base = 31*258+255 = 8253. Last wr_addr = 8191. done pulses exactly 8197 cycles after start, and busy is low in that cycle.
- stall high for 5 cycles at col=100, row=3 -> rd, col and rd_base held. wr shows a matching 5-cycle gap 4 cycles later. rd and wr totals are still 8192.
- start pulsed during SCAN and again during FIN -> ignored; exactly one done pulse, and state returns to IDLE.
- rst_n low for 1 cycle mid-scan at row 10 -> next cycle rd=0, wr=0, busy=0. No wr pulses follow, because the delay line is cleared. A new start begins again at rd_base=0.
- Back-to-back: start on the cycle after done -> second scan starts normally with wr_addr=0.

Source files
------------

// File: rtl/window_scan_ctrl_pkg.sv
// Shared constants, derived widths and FSM state type for the window scan controller.
// No logic; pure declarations.
// No flow control of its own.
package scan_pkg;

    localparam int IMG_W    = 256;
    localparam int IMG_H    = 32;
    localparam int PAD_W    = IMG_W + 2;
    localparam int RD_LAT   = 1;
    localparam int PIPE_LAT = 3;

    // One spare bit over the padded frame size (34 rows x 258 words) keeps headroom for taller tiles.
    localparam int AW  = 15;
    localparam int WAW = $clog2(IMG_W * IMG_H);
    localparam int CW  = 9;
    localparam int RW  = 6;

    // Total read-to-write latency tracked by the delay line.
    localparam int DLY_DEPTH = RD_LAT + PIPE_LAT;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    // Going from (r, IMG_W-1) to (r+1, 0) skips the two pad words and moves one column.
    localparam logic [AW-1:0] ROW_STEP = AW'(PAD_W - IMG_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Bundles the scheduler handshake, the window-read bus and the result-write bus.
// No logic; wiring only.
// stall is the only backpressure; master is the controller side.
interface window_scan_ctrl_if;
    import scan_pkg::*;

    logic           start;
    logic           stall;
    logic           rd;
    logic [AW-1:0]  rd_base;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           wr;
    logic [WAW-1:0] wr_addr;
    logic           busy;
    logic           done;

    modport master (
        input  start, stall,
        output rd, rd_base, col, row, wr, wr_addr, busy, done
    );

    modport slave (
        output start, stall,
        input  rd, rd_base, col, row, wr, wr_addr, busy, done
    );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register tracking read and kernel latency.
// Latency: DEPTH cycles from din to dout; bubbles are preserved.
// Never stalls; pending reports entries still short of the output stage.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic pending
);

    logic [DEPTH-1:0] stage;

    // Shift one slot per cycle, newest entry at bit 0; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= (stage << 1) | DEPTH'(din);
        end
    end

    assign dout    = stage[DEPTH-1];
    // The output slot is excluded: when only it is set, the last write is happening now.
    assign pending = |(stage << 1);

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-order 3x3 window read sequencer with latency-matched result write strobe.
// Latency: first rd 1 cycle after start; wr trails each rd by RD_LAT+PIPE_LAT cycles.
// stall freezes read issue only; the kernel pipeline keeps moving and carries bubbles.
module window_scan_ctrl
    import scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    window_scan_ctrl_if.master scan
);

    scan_state_t    state;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [AW-1:0]  base_q;
    logic [WAW-1:0] wr_addr_q;
    logic           busy_q;
    logic           done_q;
    logic           rd_now;
    logic           wr_now;
    logic           dly_pending;

    // Read issue depends on the current cycle's stall, so it is not registered.
    assign rd_now = (state == SCAN) && !scan.stall;

    valid_delay_line #(
        .DEPTH (DLY_DEPTH)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (rd_now),
        .dout    (wr_now),
        .pending (dly_pending)
    );

    // Scan FSM with column/row counters and running-sum base address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    col_q  <= '0;
                    row_q  <= '0;
                    base_q <= '0;
                    done_q <= 1'b0;
                    if (scan.start) begin
                        state  <= SCAN;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (rd_now) begin
                        if (col_q == LAST_COL) begin
                            col_q  <= '0;
                            base_q <= base_q + ROW_STEP;
                            if (row_q == LAST_ROW) begin
                                state <= DRAIN;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q  <= col_q + CW'(1);
                            base_q <= base_q + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the final write is at the delay-line output this cycle.
                    if (!dly_pending) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Result address advances after every write and restarts for each tile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
        end else if (state == IDLE) begin
            wr_addr_q <= '0;
        end else if (wr_now) begin
            wr_addr_q <= wr_addr_q + WAW'(1);
        end
    end

    assign scan.rd      = rd_now;
    assign scan.rd_base = base_q;
    assign scan.col     = col_q;
    assign scan.row     = row_q;
    assign scan.wr      = wr_now;
    assign scan.wr_addr = wr_addr_q;
    assign scan.busy    = busy_q;
    assign scan.done    = done_q;

endmodule
